// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and types for the UART command responder:
//                command/response byte codes and the responder FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Command opcodes received from the host
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'

  // Response bytes returned to the host
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  // Responder FSM states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GET_ADDR   = 3'd1,
    ST_GET_DATA   = 3'd2,
    ST_REG_ACCESS = 3'd3,
    ST_READ_WAIT  = 3'd4,
    ST_SEND       = 3'd5,
    ST_SEND_HOLD  = 3'd6
  } uart_cmd_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_frame_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_timer
//  Description : Saturating inter-byte timeout counter. Counts while run is
//                high, clears on clear (clear has priority), and flags expired
//                once the count reaches TIMEOUT_CYCLES-1 while running.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_frame_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  // Width is at least one bit so degenerate settings still elaborate
  localparam int              CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Saturating counter: clear wins over run, stops at the terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && (r_count != C_LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = run && (r_count == C_LAST);

endmodule : uart_frame_timer
`default_nettype wire

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_responder
//  Description : Parses 'W' addr data / 'R' addr frames from the UART receive
//                byte stream, performs the access on an 8-bit register bus and
//                returns ACK, NAK or the read byte on the UART transmit side.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_cmd_responder
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  input  logic       tx_busy,
  output logic       tx_data_valid,
  output logic [7:0] tx_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       rx_overrun
);

  uart_cmd_state_t r_state;
  uart_cmd_state_t w_state_next;

  logic       r_is_write;   // latched opcode: 1 = write frame, 0 = read frame
  logic       r_hold_seen;  // SEND_HOLD has already spent its mandatory cycle
  logic [7:0] r_rsp;        // response byte presented on tx_data

  logic w_receiving;
  logic w_responding;
  logic w_accept_byte;      // good byte consumed by the frame parser
  logic w_load_nak;
  logic w_load_ack;
  logic w_timer_run;
  logic w_timer_clear;
  logic w_expired;

  assign w_receiving   = (r_state == ST_IDLE) || (r_state == ST_GET_ADDR) ||
                         (r_state == ST_GET_DATA);
  assign w_responding  = !w_receiving;
  assign w_accept_byte = w_receiving && rx_data_valid && !rx_error;

  // Only mid-frame states are subject to the inter-byte timeout
  assign w_timer_run   = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);
  assign w_timer_clear = rx_data_valid || !w_timer_run;

  uart_frame_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_timer_clear),
    .run     (w_timer_run),
    .expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and single-cycle strobes
  always_comb begin
    w_state_next  = r_state;
    reg_we        = 1'b0;
    reg_re        = 1'b0;
    tx_data_valid = 1'b0;
    w_load_nak    = 1'b0;
    w_load_ack    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_data_valid) begin
          if (!rx_error && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
            w_state_next = ST_GET_ADDR;
          end else begin
            w_load_nak   = 1'b1;
            w_state_next = ST_SEND;
          end
        end
      end
      ST_GET_ADDR: begin
        // A byte arriving on the expiry cycle still counts
        if (rx_data_valid) begin
          if (rx_error) begin
            w_load_nak   = 1'b1;
            w_state_next = ST_SEND;
          end else if (r_is_write) begin
            w_state_next = ST_GET_DATA;
          end else begin
            w_state_next = ST_REG_ACCESS;
          end
        end else if (w_expired) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (rx_data_valid) begin
          if (rx_error) begin
            w_load_nak   = 1'b1;
            w_state_next = ST_SEND;
          end else begin
            w_state_next = ST_REG_ACCESS;
          end
        end else if (w_expired) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_REG_ACCESS: begin
        if (r_is_write) begin
          reg_we       = 1'b1;
          w_load_ack   = 1'b1;
          w_state_next = ST_SEND;
        end else begin
          reg_re       = 1'b1;
          w_state_next = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: begin
        w_state_next = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_data_valid = 1'b1;
          w_state_next  = ST_SEND_HOLD;
        end
      end
      ST_SEND_HOLD: begin
        // Give the transmitter a cycle to raise busy before trusting it
        if (r_hold_seen && !tx_busy) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Frame datapath: opcode, address, write data and response byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_write  <= 1'b0;
      reg_addr    <= 8'h00;
      reg_wdata   <= 8'h00;
      r_rsp       <= 8'h00;
      r_hold_seen <= 1'b0;
    end else begin
      r_hold_seen <= (r_state == ST_SEND_HOLD);
      if (w_accept_byte && (r_state == ST_IDLE)) begin
        r_is_write <= (rx_data == CMD_WRITE);
      end
      if (w_accept_byte && (r_state == ST_GET_ADDR)) begin
        reg_addr <= rx_data;
      end
      if (w_accept_byte && (r_state == ST_GET_DATA)) begin
        reg_wdata <= rx_data;
      end
      if (w_load_nak) begin
        r_rsp <= RSP_NAK;
      end else if (w_load_ack) begin
        r_rsp <= RSP_ACK;
      end else if (r_state == ST_READ_WAIT) begin
        r_rsp <= reg_rdata;
      end
    end
  end

  // Sticky overrun: any byte arriving while a response is in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_overrun <= 1'b0;
    end else if (rx_data_valid && w_responding) begin
      rx_overrun <= 1'b1;
    end
  end

  assign tx_data = r_rsp;
  assign busy    = (r_state != ST_IDLE);

endmodule : uart_cmd_responder
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_responder
//  Description : Directed self-checking bench for uart_cmd_responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_cmd_responder;

  localparam int TB_TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_data_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_error = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_data_valid;
  logic [7:0] tx_data;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       rx_overrun;

  int vectors    = 0;
  int miscompares = 0;

  uart_cmd_responder #(
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data_valid (rx_data_valid),
    .rx_data       (rx_data),
    .rx_error      (rx_error),
    .tx_busy       (tx_busy),
    .tx_data_valid (tx_data_valid),
    .tx_data       (tx_data),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_we        (reg_we),
    .reg_re        (reg_re),
    .reg_rdata     (reg_rdata),
    .busy          (busy),
    .rx_overrun    (rx_overrun)
  );

  always #5 clk = ~clk;

  // Register bus model: read data appears the cycle after reg_re
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h22] = 8'h3C;
    mem[8'h33] = 8'h5A;
  end
  always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

  // Cycle counter and event monitor sampled mid-cycle
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         we_cnt = 0, re_cnt = 0, tx_cnt = 0;
  int         we_cyc = 0, re_cyc = 0, tx_cyc = 0, rx_cyc = 0;
  logic [7:0] we_addr = 0, we_data = 0, re_addr = 0, tx_byte = 0;
  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt <= we_cnt + 1; we_addr <= reg_addr; we_data <= reg_wdata; we_cyc <= cyc;
    end
    if (reg_re) begin
      re_cnt <= re_cnt + 1; re_addr <= reg_addr; re_cyc <= cyc;
    end
    if (tx_data_valid) begin
      tx_cnt <= tx_cnt + 1; tx_byte <= tx_data; tx_cyc <= cyc;
    end
    if (rx_data_valid) rx_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(posedge clk); #1;
    rx_data_valid = 1'b1; rx_data = b; rx_error = err;
    @(posedge clk); #1;
    rx_data_valid = 1'b0; rx_error = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  int we_b, re_b, tx_b, strobe_c, rel_c;

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_txv",   32'(tx_data_valid), 0);
    check("rst_txd",   32'(tx_data),   0);
    check("rst_addr",  32'(reg_addr),  0);
    check("rst_wdata", 32'(reg_wdata), 0);
    check("rst_strb",  32'({reg_we, reg_re}), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_ovr",   32'(rx_overrun), 0);

    // ---- write frame ----
    we_b = we_cnt; re_b = re_cnt; tx_b = tx_cnt;
    send_byte(8'h57, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'hA5, 1'b0);
    strobe_c = rx_cyc;
    wait_idle("wr_idle");
    check("wr_we_cnt", 32'(we_cnt - we_b), 1);
    check("wr_addr",   32'(we_addr), 32'h10);
    check("wr_data",   32'(we_data), 32'hA5);
    check("wr_we_lat", 32'(we_cyc - strobe_c), 1);
    check("wr_tx_cnt", 32'(tx_cnt - tx_b), 1);
    check("wr_tx",     32'(tx_byte), 32'h06);
    check("wr_tx_lat", 32'(tx_cyc - we_cyc), 1);
    check("wr_re_cnt", 32'(re_cnt - re_b), 0);
    check("wr_hold",   32'({reg_addr, reg_wdata}), 32'h10A5);

    // ---- read frame ----
    we_b = we_cnt; re_b = re_cnt; tx_b = tx_cnt;
    send_byte(8'h52, 1'b0);
    send_byte(8'h22, 1'b0);
    strobe_c = rx_cyc;
    wait_idle("rd_idle");
    check("rd_re_cnt", 32'(re_cnt - re_b), 1);
    check("rd_addr",   32'(re_addr), 32'h22);
    check("rd_re_lat", 32'(re_cyc - strobe_c), 1);
    check("rd_tx_cnt", 32'(tx_cnt - tx_b), 1);
    check("rd_tx",     32'(tx_byte), 32'h3C);
    check("rd_tx_lat", 32'(tx_cyc - re_cyc), 2);
    check("rd_we_cnt", 32'(we_cnt - we_b), 0);

    // ---- unknown opcode ----
    we_b = we_cnt; re_b = re_cnt; tx_b = tx_cnt;
    send_byte(8'h41, 1'b0);
    wait_idle("nak_idle");
    check("nak_tx_cnt", 32'(tx_cnt - tx_b), 1);
    check("nak_tx",     32'(tx_byte), 32'h15);
    check("nak_strb",   32'((we_cnt - we_b) + (re_cnt - re_b)), 0);

    // ---- timeout mid write frame ----
    we_b = we_cnt; tx_b = tx_cnt;
    send_byte(8'h57, 1'b0);
    send_byte(8'h10, 1'b0);
    repeat (TB_TIMEOUT - 1) @(posedge clk);
    #1 check("to_busy_last", 32'(busy), 1);
    @(posedge clk); #1;
    check("to_busy_fell", 32'(busy), 0);
    repeat (5) @(posedge clk);
    #1 check("to_no_rsp", 32'(tx_cnt - tx_b), 0);
    check("to_no_we",  32'(we_cnt - we_b), 0);
    re_b = re_cnt; tx_b = tx_cnt;
    send_byte(8'h52, 1'b0);
    send_byte(8'h33, 1'b0);
    wait_idle("to_rd_idle");
    check("to_rd_re",  32'(re_cnt - re_b), 1);
    check("to_rd_tx",  32'(tx_byte), 32'h5A);

    // ---- rx_error on read address byte ----
    re_b = re_cnt; tx_b = tx_cnt;
    send_byte(8'h52, 1'b0);
    send_byte(8'h22, 1'b1);
    wait_idle("err_idle");
    check("err_tx",    32'(tx_byte), 32'h15);
    check("err_tx_cnt", 32'(tx_cnt - tx_b), 1);
    check("err_no_re", 32'(re_cnt - re_b), 0);
    check("err_no_ovr", 32'(rx_overrun), 0);

    // ---- tx_busy held during SEND, byte injected ----
    tx_b = tx_cnt;
    tx_busy = 1'b1;
    send_byte(8'h41, 1'b0);
    send_byte(8'h99, 1'b0);
    repeat (47) @(posedge clk);
    #1 check("bsy_no_tx", 32'(tx_cnt - tx_b), 0);
    check("bsy_busy",  32'(busy), 1);
    check("bsy_ovr",   32'(rx_overrun), 1);
    tx_busy = 1'b0;
    rel_c = cyc;
    wait_idle("bsy_idle");
    check("bsy_tx_cnt", 32'(tx_cnt - tx_b), 1);
    check("bsy_tx_cyc", 32'(tx_cyc), 32'(rel_c));
    check("bsy_tx",     32'(tx_byte), 32'h15);

    // ---- reset during GET_DATA ----
    send_byte(8'h57, 1'b0);
    send_byte(8'h44, 1'b0);
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_addr", 32'(reg_addr), 0);
    @(posedge clk); #1;
    check("rst2_outs", 32'({tx_data_valid, tx_data, reg_addr, reg_wdata, reg_we, reg_re}), 0);
    check("rst2_flags", 32'({busy, rx_overrun}), 0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_cmd_responder
`default_nettype wire
